// File: rtl/music_rec_pkg.sv
// Shared definitions for the note recorder.
// Contents:
//   - rec_state_e : recorder state encoding (IDLE / REC / PLAY)
//   - key word layout {notes[6:0], ishigher, islower} and its field offsets
//   - default sizing constants for depth, duration width and tick divider
package music_rec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } rec_state_e;

  // Key word layout, LSB first: islower, ishigher, then the 7 one-hot notes
  localparam int KEY_W         = 9;
  localparam int KEY_LO_BIT    = 0;
  localparam int KEY_HI_BIT    = 1;
  localparam int KEY_NOTES_LSB = 2;
  localparam int KEY_NOTES_W   = 7;

  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DUR_W    = 12;
  localparam int DEF_TICK_DIV = 1000000;

endpackage

// File: rtl/note_recorder_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every DIV enabled cycles.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   clr   - synchronous restart; if en is also high, the current cycle is
//           counted as the first cycle of the new period
//   en    - count this cycle
//   tick  - high in the enabled cycle that completes a period of DIV cycles
module tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] FIRST = (DIV > 1) ? CW'(1) : CW'(0);

  logic [CW-1:0] cnt_r;

  // Tick is combinational so the consumer can act in the same cycle the period completes
  always_comb begin
    if (!en) begin
      tick = 1'b0;
    end else if (clr) begin
      tick = (DIV == 1);
    end else begin
      tick = (cnt_r == LAST);
    end
  end

  // Cycle counter within the current tick period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= en ? FIRST : '0;
    end else if (en) begin
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/note_recorder.sv
// note_recorder: records the live key stream as timed segments and replays it.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   rec_start / rec_stop  - single-cycle record control pulses
//   play_start / play_stop- single-cycle replay control pulses
//   notes, ishigher, islower          - live keyboard inputs
//   play_notes, play_higher, play_lower - replayed key outputs (registered)
//   recording, playing    - state indicators
//   full, count           - buffer status, kept valid between recordings
module note_recorder
  import music_rec_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic [6:0]        notes,
  input  logic              ishigher,
  input  logic              islower,
  output logic [6:0]        play_notes,
  output logic              play_higher,
  output logic              play_lower,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam int                ENTRY_W = KEY_W + DUR_W;
  localparam logic [DUR_W-1:0]  DUR_MAX = '1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] RD_ZERO = '0;

  rec_state_e         state_r;
  logic [KEY_W-1:0]   key_s, key_r, open_key_r, out_key_r;
  logic [DUR_W-1:0]   dur_r, dur_inc_s, close_dur_s, rd_dur_s;
  logic [ADDR_W:0]    count_r;
  logic [ADDR_W-1:0]  rd_r, nxt_rd_s;
  logic               full_r, recording_r, playing_r;
  logic               change_s, close_s, wr_en_s, expire_s, last_s;
  logic               tg_clr_s, tg_en_s, tick_s;
  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ENTRY_W-1:0] first_entry_s, rd_entry_s, nxt_entry_s;

  assign key_s = {notes, ishigher, islower};

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tg_clr_s),
    .en    (tg_en_s),
    .tick  (tick_s)
  );

  // Segment close / write decision and replay expiry decode
  always_comb begin
    change_s      = (key_r != open_key_r);
    dur_inc_s     = (tick_s && (dur_r != DUR_MAX)) ? dur_r + 1'b1 : dur_r;
    // On a key change this cycle already belongs to the new segment
    close_dur_s   = change_s ? dur_r : dur_inc_s;
    close_s       = (state_r == ST_REC) && !full_r && (change_s || rec_stop);
    wr_en_s       = close_s && (close_dur_s != '0);
    nxt_rd_s      = rd_r + 1'b1;
    first_entry_s = mem_r[RD_ZERO];
    rd_entry_s    = mem_r[rd_r];
    nxt_entry_s   = mem_r[nxt_rd_s];
    rd_dur_s      = rd_entry_s[DUR_W-1:0];
    // dur_r counts completed ticks of the current entry during replay
    expire_s      = (state_r == ST_PLAY) && tick_s && ((dur_r + 1'b1) == rd_dur_s);
    last_s        = (({1'b0, rd_r} + 1'b1) == count_r);
    tg_en_s       = (state_r != ST_IDLE);
    if (state_r == ST_IDLE) begin
      tg_clr_s = rec_start || (play_start && (count_r != '0));
    end else if (state_r == ST_REC) begin
      tg_clr_s = change_s;
    end else begin
      tg_clr_s = 1'b0;
    end
  end

  // Live key sampling register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r <= '0;
    end else begin
      key_r <= key_s;
    end
  end

  // Segment storage; contents are meaningful only below count
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[count_r[ADDR_W-1:0]] <= {open_key_r, close_dur_s};
    end
  end

  // Recorder state machine with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      full_r      <= 1'b0;
      open_key_r  <= '0;
      dur_r       <= '0;
      rd_r        <= '0;
      out_key_r   <= '0;
      recording_r <= 1'b0;
      playing_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rec_start) begin
            state_r     <= ST_REC;
            recording_r <= 1'b1;
            count_r     <= '0;
            full_r      <= 1'b0;
            open_key_r  <= key_s;
            dur_r       <= '0;
          end else if (play_start && (count_r != '0)) begin
            state_r   <= ST_PLAY;
            playing_r <= 1'b1;
            rd_r      <= '0;
            dur_r     <= '0;
            out_key_r <= first_entry_s[ENTRY_W-1:DUR_W];
          end else begin
            out_key_r <= '0;
          end
        end
        ST_REC: begin
          if (full_r) begin
            // Buffer filled on the previous cycle: leave without writing
            state_r     <= ST_IDLE;
            recording_r <= 1'b0;
          end else begin
            if (wr_en_s) begin
              count_r <= count_r + 1'b1;
              full_r  <= ((count_r + 1'b1) == DEPTH_C);
            end
            if (change_s) begin
              open_key_r <= key_r;
              dur_r      <= tick_s ? {{(DUR_W-1){1'b0}}, 1'b1} : '0;
            end else begin
              dur_r <= dur_inc_s;
            end
            if (rec_stop) begin
              state_r     <= ST_IDLE;
              recording_r <= 1'b0;
            end
          end
        end
        ST_PLAY: begin
          if (play_stop) begin
            state_r   <= ST_IDLE;
            playing_r <= 1'b0;
            out_key_r <= '0;
          end else if (expire_s) begin
            if (last_s) begin
              state_r   <= ST_IDLE;
              playing_r <= 1'b0;
              out_key_r <= '0;
            end else begin
              rd_r      <= nxt_rd_s;
              dur_r     <= '0;
              out_key_r <= nxt_entry_s[ENTRY_W-1:DUR_W];
            end
          end else if (tick_s) begin
            dur_r <= dur_r + 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          recording_r <= 1'b0;
          playing_r   <= 1'b0;
          out_key_r   <= '0;
        end
      endcase
    end
  end

  assign play_notes  = out_key_r[KEY_NOTES_LSB +: KEY_NOTES_W];
  assign play_higher = out_key_r[KEY_HI_BIT];
  assign play_lower  = out_key_r[KEY_LO_BIT];
  assign recording   = recording_r;
  assign playing     = playing_r;
  assign full        = full_r;
  assign count       = count_r;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed record/replay scenarios checked against a
// run-length model of the key stream, plus literal spot checks.
module tb_note_recorder;
  localparam int DEPTH = 4, ADDR_W = 2, DUR_W = 4, TICK_DIV = 4;
  localparam int DMAX = 15;

  logic clk = 1'b0, reset = 1'b0;
  logic rec_start = 1'b0, rec_stop = 1'b0, play_start = 1'b0, play_stop = 1'b0;
  logic [6:0] notes = 7'd0;
  logic ishigher = 1'b0, islower = 1'b0;
  logic [6:0] play_notes;
  logic play_higher, play_lower, recording, playing, full;
  logic [ADDR_W:0] count;

  int total = 0, bad = 0;

  note_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .rec_start(rec_start), .rec_stop(rec_stop),
    .play_start(play_start), .play_stop(play_stop), .notes(notes),
    .ishigher(ishigher), .islower(islower), .play_notes(play_notes),
    .play_higher(play_higher), .play_lower(play_lower), .recording(recording),
    .playing(playing), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 recording, 2 playing; segments kept as run lengths in cycles
  int m_mode, seg_cycles, m_count, p_idx, p_left;
  bit m_full, chk_en;
  logic [8:0] m_key_r, seg_key, m_out;
  logic [8:0] q_key [DEPTH];
  int q_dur [DEPTH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_full = 0; m_out = 9'd0; m_key_r = 9'd0;
    seg_cycles = 0; seg_key = 9'd0; p_idx = 0; p_left = 0;
  endtask

  task automatic m_close(input logic [8:0] k, input int c);
    int d;
    d = c / TICK_DIV;
    if (d > DMAX) d = DMAX;
    if (d > 0 && m_count < DEPTH) begin
      q_key[m_count] = k; q_dur[m_count] = d; m_count++;
      if (m_count == DEPTH) m_full = 1;
    end
  endtask

  task automatic model_edge(input bit rs, input bit rp, input bit ps, input bit pp, input logic [8:0] k);
    logic [8:0] prev;
    if (!reset) begin
      model_reset();
    end else begin
      prev = m_key_r; m_key_r = k;
      case (m_mode)
        0: if (rs) begin
             m_mode = 1; m_count = 0; m_full = 0; seg_key = k; seg_cycles = 0;
           end else if (ps && m_count > 0) begin
             m_mode = 2; p_idx = 0; p_left = q_dur[0] * TICK_DIV; m_out = q_key[0];
           end
        1: if (m_full) m_mode = 0;
           else begin
             if (prev != seg_key) begin
               m_close(seg_key, seg_cycles); seg_key = prev; seg_cycles = 1;
             end else begin
               seg_cycles++;
               if (rp) m_close(seg_key, seg_cycles);
             end
             if (rp) m_mode = 0;
           end
        default: if (pp) begin m_mode = 0; m_out = 9'd0; end
           else begin
             p_left--;
             if (p_left == 0) begin
               p_idx++;
               if (p_idx == m_count) begin m_mode = 0; m_out = 9'd0; end
               else begin p_left = q_dur[p_idx] * TICK_DIV; m_out = q_key[p_idx]; end
             end
           end
      endcase
    end
  endtask

  task automatic cyc(input bit rs, input bit rp, input bit ps, input bit pp, input logic [8:0] k);
    rec_start = rs; rec_stop = rp; play_start = ps; play_stop = pp;
    {notes, ishigher, islower} = k;
    @(posedge clk);
    model_edge(rs, rp, ps, pp, k);
    #1;
  endtask

  task automatic hold(input logic [8:0] k, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, k);
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en)
      check("outputs", {17'd0, play_notes, play_higher, play_lower, recording, playing, full, count},
            {17'd0, m_out, (m_mode == 1), (m_mode == 2), m_full, 3'(m_count)});
  end

  localparam logic [8:0] K1 = {7'b1000000, 2'b00};
  localparam logic [8:0] K2 = {7'b0100000, 2'b10};
  localparam logic [8:0] KA = {7'b0001000, 2'b01};
  localparam logic [8:0] KB = {7'b0000100, 2'b00};

  initial begin
    logic [8:0] t3k [5];
    t3k[0] = {7'b0000001, 2'b11}; t3k[1] = 9'd0; t3k[2] = {7'b0010000, 2'b10};
    t3k[3] = {7'b0000010, 2'b01}; t3k[4] = {7'b1000000, 2'b00};
    chk_en = 0;
    model_reset();
    hold(9'd0, 2);
    check("reset_count", 32'(count), 32'd0);
    check("reset_flags", {28'd0, recording, playing, full, play_higher}, 32'd0);
    reset = 1'b1;
    chk_en = 1;
    hold(9'd0, 2);

    // Test 1: record two segments and replay
    cyc(1, 0, 0, 0, K1); hold(K1, 11); hold(K2, 8); cyc(0, 1, 0, 0, 9'd0); hold(9'd0, 2);
    check("t1_count", 32'(count), 32'd2);
    check("t1_dur0", 32'(q_dur[0]), 32'd3);
    check("t1_dur1", 32'(q_dur[1]), 32'd2);
    check("t1_key1", 32'(q_key[1]), 32'(K2));
    cyc(0, 0, 1, 0, 9'd0);
    check("t1_first_note", 32'(play_notes), 32'b1000000);
    hold(9'd0, 12);
    check("t1_second_note", {24'd0, play_notes, play_higher}, {24'd0, 7'b0100000, 1'b1});
    hold(9'd0, 8);
    check("t1_end_playing", 32'(playing), 32'd0);
    hold(9'd0, 2);

    // Test 2: short glitch between held keys is dropped
    cyc(1, 0, 0, 0, KA); hold(KA, 8); hold(KB, 2); hold(KA, 8); cyc(0, 1, 0, 0, 9'd0); hold(9'd0, 2);
    check("t2_count", 32'(count), 32'd2);
    cyc(0, 0, 1, 0, 9'd0); hold(9'd0, 18);

    // Test 3: fill the buffer (includes silence and the both-flags key)
    for (int i = 0; i < 40; i++) begin
      cyc(i == 0, 0, 0, 0, t3k[i / 8]);
      if (i == 33) check("t3_full_set", {30'd0, full, recording}, {30'd0, 1'b1, 1'b1});
      if (i == 34) check("t3_rec_drop", 32'(recording), 32'd0);
    end
    check("t3_count", 32'(count), 32'd4);
    cyc(0, 0, 1, 0, 9'd0); hold(9'd0, 34);

    // Test 4: duration saturates
    cyc(1, 0, 0, 0, K2); hold(K2, 79); cyc(0, 1, 0, 0, 9'd0); hold(9'd0, 1);
    check("t4_count", 32'(count), 32'd1);
    check("t4_dur_sat", 32'(q_dur[0]), 32'd15);
    cyc(0, 0, 1, 0, 9'd0); hold(9'd0, 62);

    // Test 5: stop mid-segment, start priority, empty play
    cyc(0, 0, 1, 0, 9'd0); hold(9'd0, 10); cyc(0, 0, 0, 1, 9'd0);
    check("t5_stop_out", {24'd0, play_notes, playing}, 32'd0);
    check("t5_count_kept", 32'(count), 32'd1);
    cyc(1, 0, 1, 0, KA);
    check("t5_rec_wins", {30'd0, recording, playing}, {30'd0, 1'b1, 1'b0});
    cyc(0, 1, 0, 0, KA);
    check("t5_empty", 32'(count), 32'd0);
    cyc(0, 0, 1, 0, 9'd0);
    check("t5_no_play", 32'(playing), 32'd0);
    hold(9'd0, 2);

    // Test 6: asynchronous reset during replay
    cyc(1, 0, 0, 0, K1); hold(K1, 11); hold(K2, 8); cyc(0, 1, 0, 0, 9'd0);
    cyc(0, 0, 1, 0, 9'd0); hold(9'd0, 5);
    check("t6_pre_play", 32'(playing), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_async_out", {24'd0, play_notes, playing}, 32'd0);
    check("t6_async_count", 32'(count), 32'd0);
    model_reset();
    hold(9'd0, 2);
    reset = 1'b1;
    hold(9'd0, 2);
    cyc(0, 0, 1, 0, 9'd0);
    check("t6_idle_after", {30'd0, recording, playing}, 32'd0);
    hold(9'd0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
